// File: rtl/uart_pkg.sv
// Shared UART transmitter types and constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; pointers wrap naturally, occupancy kept in level_q.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] wdata_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [LW-1:0]             level_o
);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]             level_q;
  logic                      do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter: start, 8 data bits LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module uart_tx import uart_pkg::*; #(
  parameter int unsigned CLK_DIV    = 108,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [UART_DATA_BITS-1:0]         tx_data_i,
  input  logic                              tx_valid_i,
  output logic                              tx_ready_o,
  output logic                              tx_o,
  output logic                              busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o
);

  localparam int unsigned   CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BaudMax  = CW'(CLK_DIV - 1);
  localparam logic [2:0]    LastData = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    LastStop = 3'(STOP_BITS - 1);

  uart_tx_state_e            state_q;
  logic [CW-1:0]             baud_q;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      tx_q, tick, fifo_pop, fifo_full, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                      par_q;
`endif

  assign tick = (baud_q == '0);
  // Popping at the final stop tick chains the next frame with no idle gap.
  assign fifo_pop = ~fifo_empty &
                    ((state_q == IDLE) | ((state_q == STOP) & tick & (bit_q == LastStop)));

  assign tx_ready_o = ~fifo_full;
  assign tx_o       = tx_q;
  assign busy_o     = (state_q != IDLE) | ~fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid_i),
    .wdata_i (tx_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // tx follows the state one cycle later, so every bit still lasts CLK_DIV cycles.
      unique case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  tx_q <= par_q;
`endif
        default: tx_q <= UART_IDLE_LVL;
      endcase

      if (state_q != IDLE) begin
        baud_q <= tick ? BaudMax : baud_q - CW'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            shift_q <= fifo_rdata;
            baud_q  <= BaudMax;
            bit_q   <= '0;
            state_q <= START;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^fifo_rdata;
`endif
          end
        end
        START: begin
          if (tick) begin
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_q == LastData) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) state_q <= STOP;
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_q == LastStop) begin
              bit_q <= '0;
              if (fifo_pop) begin
                shift_q <= fifo_rdata;
                state_q <= START;
`ifdef UART_TX_PARITY_EN
                par_q   <= ^fifo_rdata;
`endif
              end else begin
                state_q <= IDLE;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
